cpu_step_ctrl: RTL
==================

Name: cpu_step_ctrl

Overview:
Clock-enable generator that drives the simple computer's execution rate from the board controls. Consumes the raw user push-button and the two slide switches. Produces a single-cycle cpu_en pulse in the clk domain: free-running at a fast or slow rate, or one pulse per debounced key press in step mode. Replaces the muxed divided-clock/debounced-key CPU clock with a clean enable, and sits directly upstream of the CPU.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
FAST_HZ, 100, run-mode enable rate when rate_slow=0
SLOW_HZ, 10, run-mode enable rate when rate_slow=1
DB_MS, 20, debounce window in ms; DB_CYCLES = CLK_HZ*DB_MS/1000
SYNC_STAGES, 2, flip-flop stages on each asynchronous input (min 2)
REPEAT_MS, 500, hold time before autorepeat (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
key_n  input  1  raw push-button, active-low, asynchronous
mode_step  input  1  raw switch: 1=single-step, 0=run; asynchronous
rate_slow  input  1  raw switch: 1=SLOW_HZ, 0=FAST_HZ; asynchronous
halt  input  1  clk-domain level; 1 suppresses all enables
cpu_en  output  1  one-cycle enable to the CPU
step_count  output  16  count of cpu_en pulses issued
state  output  2  FSM state: 0=RUN, 1=STEP, 2=STEP_HELD, 3=HALT

Behaviour:
- One clock domain (clk); reset is synchronous and active-high. Every register updates only on the rising edge of clk.
- Reset values:
  - cpu_en=0, step_count=0, state=STEP(1), divider=0, debounce counter=0.
  - key_n synchronizer and debounced key = 1 (released).
  - mode/rate synchronizers = 0.
- Synchronization: key_n, mode_step and rate_slow each pass through SYNC_STAGES flops. halt is used directly.
- Debounce:
  - The stable key level updates only after the synchronized key differs from it for DB_CYCLES consecutive cycles.
  - Any agreeing sample clears the counter.
  - press = stable level falls 1->0. release = stable level rises 0->1.
- Divider:
  - DIV = CLK_HZ/SLOW_HZ when rate_slow=1, else CLK_HZ/FAST_HZ.
  - Counts 0..DIV-1. Asserts the terminal tick in the cycle it equals DIV-1, then wraps to 0.
  - Cleared on entering RUN and on any change of the synchronized rate_slow.
- FSM, evaluated each cycle with priority halt > mode > key:
  - Any state, halt=1 -> HALT. No cpu_en is issued in the transition cycle.
  - HALT, halt=0 -> RUN if mode=0, else STEP.
  - RUN: cpu_en = divider terminal tick. mode=1 -> STEP. Key presses are ignored.
  - STEP: press -> cpu_en=1 in the cycle after the stable level falls, then STEP_HELD. mode=0 -> RUN.
  - STEP_HELD: release -> STEP. mode=0 -> RUN. No further pulses (base build).
- Latencies:
  - Step mode, key_n held low continuously: cpu_en asserts exactly SYNC_STAGES+DB_CYCLES+1 cycles after the first low sample.
  - Run mode: first pulse DIV cycles after RUN entry, then every DIV cycles.
- Mode switch mid-count: the divider restarts from 0 and no partial-period pulse is issued.
- step_count increments by 1 in the cycle after each cpu_en. It wraps 0xFFFF->0x0000.
- cpu_en is never high on two consecutive cycles when DIV>=2.
- Reset asserted mid-operation: next edge returns all outputs to their reset values, and any pending press is discarded.

Optional Feature:
STEP_AUTOREPEAT_EN
- Defined: in STEP_HELD, if the key stays stably pressed for REPEAT_MS, cpu_en pulses every CLK_HZ/SLOW_HZ cycles while held. The repeat timer is reused from the divider. Release or mode change stops the pulses immediately.
- Undefined: exactly one cpu_en per press; REPEAT_MS is unused.

Test Plan:
All cases use CLK_HZ=1000, FAST_HZ=100 (DIV=10), SLOW_HZ=10 (DIV=100), DB_MS=4 (DB_CYCLES=4), SYNC_STAGES=2.
1. Reset then mode_step=0, rate_slow=0 -> state=RUN; cpu_en pulses every 10 cycles; step_count=5 after 50 cycles in RUN.
2. Step mode: key_n low for 20 cycles -> exactly one cpu_en, 7 cycles after the first low sample; state=STEP_HELD; step_count=1. Release -> STEP.
3. Step mode: key_n glitches low for 3 cycles (less than DB_CYCLES) -> no cpu_en; step_count unchanged.
4. RUN, toggle rate_slow 0->1 at divider=7 -> no pulse at the old period; next cpu_en 100 cycles after the synchronized change.
5. RUN, halt=1 for 50 cycles -> state=HALT, cpu_en=0 throughout; halt=0 -> first cpu_en 10 cycles later.
6. Preload step_count=0xFFFF, one step press -> step_count=0x0000; reset mid-RUN -> cpu_en=0, state=STEP, step_count=0.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// Clock-enable generator for the CPU: free-running fast/slow enable or one pulse per debounced key.
// Optional build macro STEP_AUTOREPEAT_EN adds autorepeat while the step key is held.
module cpu_step_ctrl #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned FAST_HZ     = 100,
    parameter int unsigned SLOW_HZ     = 10,
    parameter int unsigned DB_MS       = 20,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned REPEAT_MS   = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_n,
    input  logic        mode_step,
    input  logic        rate_slow,
    input  logic        halt,
    output logic        cpu_en,
    output logic [15:0] step_count,
    output logic [1:0]  state
);

    localparam int unsigned DIV_FAST      = CLK_HZ / FAST_HZ;
    localparam int unsigned DIV_SLOW      = CLK_HZ / SLOW_HZ;
    localparam int unsigned DB_CYCLES     = 32'((64'(CLK_HZ) * 64'(DB_MS)) / 64'd1000);
    localparam int unsigned REPEAT_CYCLES = 32'((64'(CLK_HZ) * 64'(REPEAT_MS)) / 64'd1000);
    localparam int unsigned DIV_BASE_MAX  = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    // Divider is sized for the autorepeat hold too, so both builds share one register layout.
    localparam int unsigned CNT_MAX       = (REPEAT_CYCLES > DIV_BASE_MAX) ? REPEAT_CYCLES
                                                                           : DIV_BASE_MAX;
    localparam int unsigned DIV_W         = $clog2(CNT_MAX + 1);
    localparam int unsigned DB_W          = $clog2(DB_CYCLES + 1);

    localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(DIV_FAST - 1);
    localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(DIV_SLOW - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
`ifdef STEP_AUTOREPEAT_EN
    localparam logic [DIV_W-1:0] REPEAT_LAST = DIV_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StStep     = 2'd1,
        StStepHeld = 2'd2,
        StHalt     = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] key_sync_q, mode_sync_q, rate_sync_q;
    logic                   key_stable_q, key_stable_d, key_prev_q;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [DIV_W-1:0]       div_q, div_d, div_last;
    state_e                 state_q, state_d;
    logic                   cpu_en_q, cpu_en_d;
    logic [15:0]            step_count_q;
`ifdef STEP_AUTOREPEAT_EN
    logic                   rep_armed_q, rep_armed_d;
`endif

    logic key_s, mode_s, rate_s, rate_chg, div_tick, key_press, key_rel;

    assign key_s  = key_sync_q[SYNC_STAGES-1];
    assign mode_s = mode_sync_q[SYNC_STAGES-1];
    assign rate_s = rate_sync_q[SYNC_STAGES-1];
    // Rate change is seen one stage early so the divider restarts on the edge rate_s flips.
    assign rate_chg  = rate_sync_q[SYNC_STAGES-1] != rate_sync_q[SYNC_STAGES-2];
    assign div_last  = rate_s ? SLOW_LAST : FAST_LAST;
    assign div_tick  = !rate_chg && (div_q == div_last);
    assign key_press = key_prev_q & ~key_stable_q;
    assign key_rel   = ~key_prev_q & key_stable_q;

    always_comb begin
        key_stable_d = key_stable_q;
        db_cnt_d     = '0;
        if (key_s != key_stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_stable_d = key_s;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        div_d    = (div_tick || rate_chg) ? '0 : div_q + DIV_W'(1);
`ifdef STEP_AUTOREPEAT_EN
        rep_armed_d = rep_armed_q;
`endif
        if (halt) begin
            state_d = StHalt;
        end else begin
            unique case (state_q)
                StHalt: state_d = mode_s ? StStep : StRun;
                StRun: begin
                    if (mode_s) begin
                        state_d = StStep;
                    end else begin
                        cpu_en_d = div_tick;
                    end
                end
                StStep: begin
                    if (!mode_s) begin
                        state_d = StRun;
                    end else if (key_press) begin
                        cpu_en_d = 1'b1;
                        state_d  = StStepHeld;
`ifdef STEP_AUTOREPEAT_EN
                        div_d       = '0;
                        rep_armed_d = 1'b0;
`endif
                    end
                end
                StStepHeld: begin
                    if (!mode_s) begin
                        state_d = StRun;
                    end else if (key_rel) begin
                        state_d = StStep;
                    end
`ifdef STEP_AUTOREPEAT_EN
                    else begin
                        // Divider doubles as the hold timer, then as the slow repeat period.
                        div_d = div_q + DIV_W'(1);
                        if (!rep_armed_q) begin
                            if (div_q == REPEAT_LAST) begin
                                cpu_en_d    = 1'b1;
                                rep_armed_d = 1'b1;
                                div_d       = '0;
                            end
                        end else if (div_q == SLOW_LAST) begin
                            cpu_en_d = 1'b1;
                            div_d    = '0;
                        end
                    end
`endif
                end
            endcase
        end
        if (state_d == StRun && state_q != StRun) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_sync_q   <= '1;
            mode_sync_q  <= '0;
            rate_sync_q  <= '0;
            key_stable_q <= 1'b1;
            key_prev_q   <= 1'b1;
            db_cnt_q     <= '0;
            div_q        <= '0;
            state_q      <= StStep;
            cpu_en_q     <= 1'b0;
            step_count_q <= '0;
`ifdef STEP_AUTOREPEAT_EN
            rep_armed_q  <= 1'b0;
`endif
        end else begin
            key_sync_q   <= {key_sync_q[SYNC_STAGES-2:0], key_n};
            mode_sync_q  <= {mode_sync_q[SYNC_STAGES-2:0], mode_step};
            rate_sync_q  <= {rate_sync_q[SYNC_STAGES-2:0], rate_slow};
            key_stable_q <= key_stable_d;
            key_prev_q   <= key_stable_q;
            db_cnt_q     <= db_cnt_d;
            div_q        <= div_d;
            state_q      <= state_d;
            cpu_en_q     <= cpu_en_d;
            step_count_q <= step_count_q + {15'd0, cpu_en_q};
`ifdef STEP_AUTOREPEAT_EN
            rep_armed_q  <= rep_armed_d;
`endif
        end
    end

    assign cpu_en     = cpu_en_q;
    assign step_count = step_count_q;
    assign state      = state_q;

endmodule
